ksa: RTL and testbench
======================

Name: ksa

Overview:
- Key-scheduling stage of the RC4 datapath, directly downstream of the S-array initialiser.
- Once the initialiser has written S[i]=i, this block runs the 256-iteration RC4 key schedule on the same 256x8 S memory: j = j + S[i] + key[i mod KEY_BYTES], then swap S[i] and S[j].
- It drives the S memory port through the top-level mux and uses the same rdy/en handshake as the other lab3 stages.

Parameters:
KEY_BYTES, 3, number of key bytes; the key byte for iteration i is selected by i mod KEY_BYTES.

Ports:
clk      input   1               system clock, rising edge
rst      input   1               asynchronous active-high reset
en       input   1               start request; sampled only while rdy=1
rdy      output  1               1 = idle, ready to accept en
key      input   8*KEY_BYTES     secret key, big-endian; byte 0 = key[8*KEY_BYTES-1 -: 8]
addr     output  8               S memory address
rddata   input   8               S memory read data; valid the cycle after addr is presented with wren=0
wrdata   output  8               S memory write data
wren     output  1               S memory write enable

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; rdy=1, wren=0, addr=0, wrdata=0.
  - Internal i, j, si, sj and the key-index counter cleared.
- Handshake:
  - en=1 with rdy=1 at a rising edge: latch key, set i=0, j=0, kidx=0, go to RD_I; rdy=0 from that edge.
  - en while rdy=0 is ignored; the key is not re-latched.
- Outputs are registered and change only on clock edges (or reset).
- States, one clock each:
  - IDLE: rdy=1, wren=0, addr holds last value.
  - RD_I: addr=i, wren=0. -> WT_I
  - WT_I: si<=rddata; j<=j+rddata+keybyte[kidx] (mod 256). -> RD_J
  - RD_J: addr=j (updated), wren=0. -> WT_J
  - WT_J: sj<=rddata. -> WR_I
  - WR_I: addr=i, wrdata=sj, wren=1. -> WR_J
  - WR_J: addr=j, wrdata=si, wren=1.
    - i==255: -> IDLE, rdy=1 on the following edge, wren=0.
    - else: i<=i+1, kidx<=(kidx==KEY_BYTES-1)?0:kidx+1. -> RD_I
- Latency:
  - 6 cycles per iteration; 1536 cycles from the en edge to the rdy=1 edge.
  - Exactly 512 write cycles per run.
- Arithmetic: all 8-bit with silent wrap; i is 8-bit and terminates on ==255, not on overflow.
- kidx is a modular counter; no divider or modulo operator.
- i==j: both writes go to the same address; the final value is si (==sj). This is correct and needs no special-casing.
- Reset mid-run: immediate abort to IDLE with the reset values. Memory contents are undefined and the initialiser must be rerun.
- en held high continuously: a new run starts on the first edge where rdy=1. The re-run operates on the already-scheduled S.
- The block never asserts wren in IDLE, RD_I, WT_I, RD_J or WT_J.

Test Plan:
1. Reset behaviour:
   - Stimulus: rst=1 mid-run (e.g. cycle 100 after en), then rst=0 and 3 clocks.
   - Required: rdy=1, wren=0, addr=0, wrdata=0 immediately and for the following 3 clocks with en=0.
2. Zero key:
   - Stimulus: key=24'h000000, S preloaded with S[i]=i, pulse en.
   - Required: iterations 0 and 1 write addr 0/0 and 1/1 (self-swaps, data 0 and 1); iteration 2 computes j=3 and writes addr 2 data 3, then addr 3 data 2.
3. Lab key:
   - Stimulus: key=24'h00033C.
   - Required iteration 0: j=0, self-swap at addr 0.
   - Required iteration 1: j=4; WR_I writes addr 1 data 4, WR_J writes addr 4 data 1.
   - Required final state: all 256 S bytes match a behavioural RC4 KSA model.
4. Timing and protocol:
   - Stimulus: count cycles over a full run.
   - Required: rdy=1 exactly 1536 cycles after the en edge; 512 wren pulses; no wren while rdy=1.
5. Ignored en and restart:
   - Stimulus: toggle en and change key while busy.
   - Required: no effect on the run; the result equals the run with the originally latched key.
   - Stimulus: pulse en after completion.
   - Required: a second run starts and rdy drops on the next edge.
6. Wrap:
   - Stimulus: key=24'hFFFFFF.
   - Required: j wraps mod 256 (iteration 0 gives j=8'hFF, swap S[0]/S[255]); final S matches the model.

Source files
------------

// File: rtl/ksa_if.sv
// ksa_if: S-memory / handshake bundle for the RC4 key-schedule stage.
//   en, key    : start request and secret key (host -> ksa)
//   rdy        : idle / ready to accept en (ksa -> host)
//   addr, wrdata, wren : S memory port driven by ksa
//   rddata     : S memory read data, one cycle after addr (memory -> ksa)
// The master side is the environment (host plus S memory), the slave is ksa.
interface ksa_if #(
  parameter int KEY_BYTES = 3
);
  logic                   en;
  logic                   rdy;
  logic [8*KEY_BYTES-1:0] key;
  logic [7:0]             addr;
  logic [7:0]             rddata;
  logic [7:0]             wrdata;
  logic                   wren;

  modport master (output en, key, rddata, input rdy, addr, wrdata, wren);
  modport slave  (input en, key, rddata, output rdy, addr, wrdata, wren);
endinterface

// File: rtl/ksa.sv
// ksa: RC4 key-scheduling stage. Runs 256 iterations of
//   j = j + S[i] + key[i mod KEY_BYTES]; swap(S[i], S[j])
// over an external 256x8 S memory with a one-cycle read latency.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : ksa_if slave (en/rdy handshake, key, S memory port)
// Each iteration takes six states (RD_I, WT_I, RD_J, WT_J, WR_I, WR_J), so a
// run is 1536 cycles with 512 write cycles. All outputs are registered.
module ksa #(
  parameter int KEY_BYTES = 3
) (
  input  logic clk,
  input  logic rst,
  ksa_if.slave bus
);
  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J
  } state_t;

  state_t                 state;
  logic [7:0]             i, j, si;
  logic [KW-1:0]          kidx;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             kb;
  logic [7:0]             j_nxt;

  // Key byte 0 is the most significant byte of the key.
  always_comb begin
    kb = '0;
    for (int b = 0; b < KEY_BYTES; b++)
      if (kidx == KW'(b)) kb = key_q[8*(KEY_BYTES-1-b) +: 8];
  end

  // Valid in WT_I, when rddata carries S[i].
  assign j_nxt = 8'(j + bus.rddata + kb);

  // S[j] is read into the wrdata register directly in WT_J; that register
  // is the sj holding register for the WR_I write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bus.rdy    <= 1'b1;
      bus.wren   <= 1'b0;
      bus.addr   <= '0;
      bus.wrdata <= '0;
      i          <= '0;
      j          <= '0;
      si         <= '0;
      kidx       <= '0;
      key_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            key_q   <= bus.key;
            i       <= '0;
            j       <= '0;
            kidx    <= '0;
            bus.rdy <= 1'b0;
            bus.addr <= '0;
            state   <= RD_I;
          end
        end
        RD_I: state <= WT_I;
        WT_I: begin
          si       <= bus.rddata;
          j        <= j_nxt;
          bus.addr <= j_nxt;
          state    <= RD_J;
        end
        RD_J: state <= WT_J;
        WT_J: begin
          bus.addr   <= i;
          bus.wrdata <= bus.rddata;
          bus.wren   <= 1'b1;
          state      <= WR_I;
        end
        WR_I: begin
          bus.addr   <= j;
          bus.wrdata <= si;
          state      <= WR_J;
        end
        WR_J: begin
          bus.wren <= 1'b0;
          if (i == 8'hFF) begin
            bus.rdy <= 1'b1;
            state   <= IDLE;
          end else begin
            i        <= 8'(i + 8'd1);
            bus.addr <= 8'(i + 8'd1);
            kidx     <= (kidx == KW'(KEY_BYTES-1)) ? '0 : KW'(kidx + 1'b1);
            state    <= RD_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ksa.sv
// tb_ksa: bench for ksa. Provides a synchronous-read S memory, logs every
// write cycle, and compares each run against an arithmetic RC4 KSA model
// (expected write sequence, final S contents, latency), plus a table of
// hand-derived first writes and reset / restart / ignored-en sequences.
module tb_ksa;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ksa_if #(.KEY_BYTES(3)) bus ();
  ksa #(.KEY_BYTES(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  // S memory: one-cycle read latency, write on wren.
  logic [7:0] mem [256];
  logic       preload = 1'b0;
  always @(posedge clk) begin
    if (preload) for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    else if (bus.wren) mem[bus.addr] <= bus.wrdata;
    bus.rddata <= mem[bus.addr];
  end

  // Write log and idle-write monitor, sampled mid-cycle.
  int wlog[$];
  int viol = 0;
  always @(negedge clk) begin
    if (!rst && bus.wren) begin
      wlog.push_back(int'({bus.addr, bus.wrdata}));
      if (bus.rdy) viol++;
    end
  end

  int nvec = 0, nerr = 0;
  int base = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    nvec++;
    if (act != exp_v) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp_v, exp_v);
    end
  endtask

  // Reference model: plain RC4 KSA over ms[], recording the expected writes.
  logic [7:0] ms [256];
  int expw[$];
  function automatic void model_run(input logic [23:0] k);
    int jj;
    logic [7:0] t;
    jj = 0;
    expw.delete();
    for (int ii = 0; ii < 256; ii++) begin
      jj = (jj + int'(ms[ii]) + int'(k[8*(2-(ii%3)) +: 8])) % 256;
      expw.push_back(ii*256 + int'(ms[jj]));
      expw.push_back(jj*256 + int'(ms[ii]));
      t = ms[ii]; ms[ii] = ms[jj]; ms[jj] = t;
    end
  endfunction

  task automatic do_preload();
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
    for (int k = 0; k < 256; k++) ms[k] = 8'(k);
  endtask

  task automatic start_run(input logic [23:0] k, input bit hold);
    @(negedge clk);
    base = wlog.size();
    bus.key = k;
    bus.en  = 1'b1;
    @(posedge clk); #1;
    chk("start_rdy", int'(bus.rdy), 0);
    if (!hold) bus.en = 1'b0;
  endtask

  // Counts edges from the en edge up to the edge that raises rdy.
  task automatic wait_done(input bit noise);
    int cyc;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (noise) begin
        if (cyc < 1500) begin
          bus.en  = 1'($urandom_range(0, 1));
          bus.key = 24'($urandom);
        end else bus.en = 1'b0;
      end
      @(posedge clk); cyc++; #1;
      if (bus.rdy || cyc >= 2000) break;
    end
    chk("latency", cyc, 1536);
  endtask

  task automatic check_run(input string tag);
    int nwr, bad;
    nwr = wlog.size() - base;
    chk({tag, "_nwr"}, nwr, 512);
    bad = 0;
    for (int k = 0; k < nwr && k < 512; k++)
      if (wlog[base+k] != expw[k]) bad++;
    chk({tag, "_wrseq"}, bad, 0);
    bad = 0;
    for (int k = 0; k < 256; k++)
      if (mem[k] != ms[k]) bad++;
    chk({tag, "_sfinal"}, bad, 0);
  endtask

  task automatic do_run(input logic [23:0] k, input string tag);
    do_preload();
    model_run(k);
    start_run(k, 1'b0);
    wait_done(1'b0);
    check_run(tag);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdy"},    int'(bus.rdy),    1);
    chk({tag, "_wren"},   int'(bus.wren),   0);
    chk({tag, "_addr"},   int'(bus.addr),   0);
    chk({tag, "_wrdata"}, int'(bus.wrdata), 0);
  endtask

  typedef struct {
    logic [23:0] key;
    int          widx;
    logic [7:0]  addr;
    logic [7:0]  data;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic [23:0] k, lastk;
    bit have;

    // Hand-derived first writes (index into the run's write log).
    vt[0]  = '{24'h000000, 0, 8'd0,   8'd0};
    vt[1]  = '{24'h000000, 1, 8'd0,   8'd0};
    vt[2]  = '{24'h000000, 2, 8'd1,   8'd1};
    vt[3]  = '{24'h000000, 3, 8'd1,   8'd1};
    vt[4]  = '{24'h000000, 4, 8'd2,   8'd3};
    vt[5]  = '{24'h000000, 5, 8'd3,   8'd2};
    vt[6]  = '{24'h00033C, 0, 8'd0,   8'd0};
    vt[7]  = '{24'h00033C, 1, 8'd0,   8'd0};
    vt[8]  = '{24'h00033C, 2, 8'd1,   8'd4};
    vt[9]  = '{24'h00033C, 3, 8'd4,   8'd1};
    vt[10] = '{24'hFFFFFF, 0, 8'd0,   8'd255};
    vt[11] = '{24'hFFFFFF, 1, 8'd255, 8'd0};

    bus.en  = 1'b0;
    bus.key = '0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outs("por");
    @(negedge clk) rst = 1'b0;

    have = 1'b0;
    lastk = '0;
    for (int v = 0; v < 12; v++) begin
      if (!have || vt[v].key != lastk) begin
        do_run(vt[v].key, $sformatf("key%06h", vt[v].key));
        have = 1'b1;
        lastk = vt[v].key;
      end
      if (base + vt[v].widx < wlog.size())
        chk($sformatf("tbl%0d", v), wlog[base + vt[v].widx], int'({vt[v].addr, vt[v].data}));
      else
        chk($sformatf("tbl%0d_missing", v), 0, 1);
    end

    // Random keys; runs after the first continue on the scheduled S.
    do_preload();
    for (int r = 0; r < 3; r++) begin
      k = 24'($urandom);
      model_run(k);
      start_run(k, 1'b0);
      wait_done(1'b0);
      check_run($sformatf("rand%0d", r));
    end

    // en toggling and key changes while busy must not disturb the run.
    do_preload();
    k = 24'($urandom);
    model_run(k);
    start_run(k, 1'b0);
    wait_done(1'b1);
    check_run("noise");

    // en held high: a new run starts on the first edge with rdy=1.
    k = 24'($urandom);
    model_run(k);
    start_run(k, 1'b1);
    wait_done(1'b0);
    check_run("hold1");
    @(posedge clk); #1;
    chk("restart_rdy", int'(bus.rdy), 0);
    bus.en = 1'b0;
    base = wlog.size();
    model_run(k);
    wait_done(1'b0);
    check_run("hold2");

    // Reset mid-run: immediate abort, then idle with en low.
    do_preload();
    start_run(24'h00033C, 1'b0);
    repeat (100) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1 chk_reset_outs("rst_now");
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_reset_outs($sformatf("rst_after%0d", c));
    end

    do_run(24'h00033C, "recover");

    chk("wren_while_rdy", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
